// File: rtl/goertzel_loop_engine.sv
// Goertzel recursion engine: walks one sample bank through s[n] = x + coeff*s[n-1] - s[n-2]
// and leaves s[N-1]/s[N-2] on T1/T2. Every instance follows the same cycle sequence.
module goertzel_loop_engine #(
  parameter int unsigned D_W         = 8,
  parameter int unsigned A_W         = 9,
  parameter int unsigned NUM_SAMPLES = 512,
  parameter int unsigned C_FRAC      = 14
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           enable,
  input  logic           start,
  input  logic [15:0]    coeff,
  input  logic [D_W-1:0] data_n,
  output logic [15:0]    T1,
  output logic [15:0]    T2,
  output logic [A_W-1:0] read_address,
  output logic           ready,
  output logic           done
);

  localparam logic [A_W-1:0] LastIdx = A_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StMul,
    StAcc,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    t1_q, t1_d;
  logic [15:0]    t2_q, t2_d;
  logic [15:0]    x_q, x_d;
  logic [15:0]    prod_q, prod_d;
  logic [A_W-1:0] count_q, count_d;
  logic [A_W-1:0] raddr_q, raddr_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;

  logic signed [31:0] prod_full;
  logic signed [31:0] prod_shift;
  logic        [15:0] s0;

  // Full-width signed product; the arithmetic shift floors toward minus infinity.
  assign prod_full  = $signed({{16{coeff[15]}}, coeff}) * $signed({{16{t1_q[15]}}, t1_q});
  assign prod_shift = prod_full >>> C_FRAC;
  assign s0         = x_q + prod_q - t2_q;

  always_comb begin
    state_d = state_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    x_d     = x_q;
    prod_d  = prod_q;
    count_d = count_q;
    raddr_d = raddr_q;
    ready_d = ready_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          t1_d    = '0;
          t2_d    = '0;
          count_d = '0;
          raddr_d = '0;
          done_d  = 1'b0;
          ready_d = 1'b0;
          state_d = StPrime;
        end
      end
      StPrime: state_d = StMul;
      StMul: begin
        x_d    = 16'(data_n);
        prod_d = prod_shift[15:0];
        // Address stays on the last sample so the bus is quiet once the run ends.
        if (count_q != LastIdx) raddr_d = raddr_q + 1'b1;
        state_d = StAcc;
      end
      StAcc: begin
        t2_d = t1_q;
        t1_d = s0;
        if (count_q == LastIdx) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = StDone;
        end else begin
          count_d = count_q + 1'b1;
          state_d = StMul;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      t1_q    <= '0;
      t2_q    <= '0;
      x_q     <= '0;
      prod_q  <= '0;
      count_q <= '0;
      raddr_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      x_q     <= x_d;
      prod_q  <= prod_d;
      count_q <= count_d;
      raddr_q <= raddr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign T1           = t1_q;
  assign T2           = t2_q;
  assign read_address = raddr_q;
  assign ready        = ready_q;
  assign done         = done_q;

endmodule

// File: tb/tb_goertzel_loop_engine.sv
// Directed bench for goertzel_loop_engine with a negedge-read RAM model and a result queue.
module tb_goertzel_loop_engine;

  localparam int NS = 512;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable  = 1'b0;
  logic        start   = 1'b0;
  logic [15:0] coeff   = 16'h4000;
  logic [7:0]  data_n  = 8'h00;
  logic [15:0] T1, T2;
  logic [8:0]  read_address;
  logic        ready, done;

  logic [7:0]  mem [NS];
  logic [31:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_cnt;

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) data_n <= mem[read_address];

  goertzel_loop_engine #(
    .D_W(8), .A_W(9), .NUM_SAMPLES(NS), .C_FRAC(14)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .start(start), .coeff(coeff),
    .data_n(data_n), .T1(T1), .T2(T2), .read_address(read_address), .ready(ready),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) chk({tag, "_queue_empty"}, obs, ~obs);
    else chk(tag, obs, exp_q.pop_front());
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < NS; i++) mem[i] = v;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_t1t2"}, {T1, T2}, 32'd0);
    chk({tag, "_raddr"}, 32'(read_address), 32'd0);
  endtask

  // Accepts a start, then steps clocks until done, the reset cycle, or the budget runs out.
  task automatic run(input bit toggle, input int start_at, input int rst_at, input bit chk_steps,
                     input bit chk_addr, output int cycles);
    start = 1'b1; enable = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    cycles = -1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      enable  = (cyc == rst_at) ? 1'b0 : (!toggle || (cyc % 2 == 0));
      start   = (cyc == start_at) || (cyc == rst_at);
      sys_rst = (cyc == rst_at);
      @(posedge sys_clk); #1;
      start = 1'b0; sys_rst = 1'b0; enable = 1'b1;
      if (cyc == rst_at) begin
        cycles = cyc;
        return;
      end
      if (chk_addr && cyc % 2 == 1 && cyc <= 2 * NS - 1)
        chk("raddr_seq", 32'(read_address), 32'((cyc - 1) / 2));
      if (chk_steps && cyc >= 3 && cyc % 2 == 1) pop_chk("acc_step", {T1, T2});
      if (done) begin
        cycles = cyc;
        return;
      end
    end
  endtask

  initial begin
    logic signed [15:0] m1, m2, ms;
    logic signed [31:0] full;
    fill(8'd0);

    // Reset dominates start and enable.
    start = 1'b1; enable = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0; start = 1'b0; enable = 1'b1;
    check_idle_zero("reset");

    // Zero samples: latency, address walk, hold in DONE.
    coeff = 16'h4000;
    exp_q.push_back(32'd0);
    run(1'b0, 0, 0, 1'b0, 1'b1, cyc_cnt);
    chk("zero_latency", 32'(cyc_cnt), 32'd1025);
    pop_chk("zero_result", {T1, T2});
    chk("zero_raddr_hold", 32'(read_address), 32'd511);
    chk("zero_ready", 32'(ready), 32'd1);
    repeat (5) @(posedge sys_clk);
    #1;
    chk("zero_done_hold", 32'(done), 32'd1);
    chk("zero_raddr_hold2", 32'(read_address), 32'd511);

    // Ones with coeff 1.0: period-6 sequence ends on s[511]=2, s[510]=1.
    fill(8'd1);
    exp_q.push_back({16'd2, 16'd1});
    run(1'b0, 0, 0, 1'b0, 1'b0, cyc_cnt);
    chk("ones_latency", 32'(cyc_cnt), 32'd1025);
    pop_chk("ones_result", {T1, T2});
    repeat (3) @(posedge sys_clk);
    #1;
    chk("ones_hold", {T1, T2}, {16'd2, 16'd1});

    // Enable toggling halves the rate but not the result.
    exp_q.push_back({16'd2, 16'd1});
    run(1'b1, 0, 0, 1'b0, 1'b0, cyc_cnt);
    chk("toggle_latency", 32'(cyc_cnt), 32'd2050);
    pop_chk("toggle_result", {T1, T2});

    // Mid-run start is ignored.
    exp_q.push_back({16'd2, 16'd1});
    run(1'b0, 100, 0, 1'b0, 1'b0, cyc_cnt);
    chk("midstart_latency", 32'(cyc_cnt), 32'd1025);
    pop_chk("midstart_result", {T1, T2});

    // Mid-run reset aborts, then a fresh run is clean.
    run(1'b0, 0, 300, 1'b0, 1'b0, cyc_cnt);
    chk("midrst_cycle", 32'(cyc_cnt), 32'd300);
    check_idle_zero("midrst");
    exp_q.push_back({16'd2, 16'd1});
    run(1'b0, 0, 0, 1'b0, 1'b0, cyc_cnt);
    chk("after_rst_latency", 32'(cyc_cnt), 32'd1025);
    pop_chk("after_rst_result", {T1, T2});

    // Full-scale samples with coeff -2.0: wrapping golden model, every ACC step.
    fill(8'd255);
    coeff = 16'h8000;
    m1 = '0; m2 = '0;
    for (int i = 0; i < NS; i++) begin
      full = $signed({{16{coeff[15]}}, coeff}) * $signed({{16{m1[15]}}, m1});
      full = full >>> 14;
      ms = 16'h00FF + full[15:0] - m2;
      m2 = m1;
      m1 = ms;
      exp_q.push_back({m1, m2});
    end
    run(1'b0, 0, 0, 1'b1, 1'b0, cyc_cnt);
    chk("neg2_latency", 32'(cyc_cnt), 32'd1025);
    chk("neg2_final", {T1, T2}, {m1, m2});
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
